// File: rtl/peripheral_div.sv
// peripheral_div: memory-mapped unsigned integer divider.
//
// The CPU writes dividend (A) and divisor (B) into shadow registers, issues a
// start through the control register, polls the status register and reads
// back quotient (Q) and remainder (R). A restoring divider retires one
// quotient bit per clock, so a nonzero-divisor division completes WIDTH
// cycles after the start edge; a zero divisor completes on the next edge
// with Q = all ones and R = A.
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x00 W  dividend shadow A
//   0x04 W  divisor shadow B
//   0x08 W  control, d_in[0] = 1 issues start
//   0x0C R  status {.., dbz, busy, done}
//   0x10 R  quotient (zero-extended)
//   0x14 R  remainder (zero-extended)
//   other   writes ignored, reads return 0
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   d_in   in   write data (WIDTH bits)
//   cs     in   chip select, qualifies rd/wr
//   addr   in   register byte offset (5 bits)
//   rd     in   read strobe
//   wr     in   write strobe
//   d_out  out  registered read data (32 bits)
//
// Configuration macro:
//   DIV_DBZ_FLAG_EN  implements the divide-by-zero flag at status bit2;
//                    without it status bit2 reads 0.

module peripheral_div #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             cs,
    input  logic [4:0]       addr,
    input  logic             rd,
    input  logic             wr,
    output logic [31:0]      d_out
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [2:0] RegA      = 3'd0;
    localparam logic [2:0] RegB      = 3'd1;
    localparam logic [2:0] RegCtrl   = 3'd2;
    localparam logic [2:0] RegStatus = 3'd3;
    localparam logic [2:0] RegQuo    = 3'd4;
    localparam logic [2:0] RegRem    = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;       // dividend shadow
    logic [WIDTH-1:0]  b_q, b_d;       // divisor shadow
    logic [WIDTH-1:0]  wa_q, wa_d;     // working dividend, becomes quotient
    logic [WIDTH-1:0]  wb_q, wb_d;     // working divisor
    logic [WIDTH-1:0]  rem_q, rem_d;   // partial remainder (always < divisor)
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [31:0]       dout_q, dout_d;
`ifdef DIV_DBZ_FLAG_EN
    logic              dbz_q, dbz_d;
`endif

    logic              wr_en;
    logic              rd_en;
    logic [2:0]        reg_sel;
    logic              start;
    logic              unused_addr_bits;

    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    rem_diff;
    logic              rem_ge;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  quo_next;

    logic [31:0]       status_word;
    logic [31:0]       q_ext;
    logic [31:0]       r_ext;
    logic [31:0]       rd_data;

    assign wr_en            = cs & wr;
    assign rd_en            = cs & rd;
    assign reg_sel          = addr[4:2];
    assign unused_addr_bits = ^addr[1:0];

    // A start arriving while a division is in flight is dropped.
    assign start = wr_en && (reg_sel == RegCtrl) && d_in[0] && (state_q != StRun);

    // One restoring step. The shifted remainder is WIDTH+1 bits so it can hold
    // up to 2*B-1. Because rem_shift < 2*B, the top bit of the difference is a
    // clean borrow flag: 0 exactly when rem_shift >= B.
    always_comb begin
        rem_shift = {rem_q, wa_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, wb_q};
        rem_ge    = ~rem_diff[WIDTH];
        rem_next  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {wa_q[WIDTH-2:0], rem_ge};
    end

    // Read data multiplexer.
    always_comb begin
        status_word    = '0;
        status_word[0] = (state_q == StDone);
        status_word[1] = (state_q == StRun);
`ifdef DIV_DBZ_FLAG_EN
        status_word[2] = dbz_q;
`endif
        q_ext              = '0;
        q_ext[WIDTH-1:0]   = q_q;
        r_ext              = '0;
        r_ext[WIDTH-1:0]   = r_q;

        unique case (reg_sel)
            RegStatus: rd_data = status_word;
            RegQuo:    rd_data = q_ext;
            RegRem:    rd_data = r_ext;
            default:   rd_data = '0;
        endcase
    end

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        wa_d    = wa_q;
        wb_d    = wb_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dout_d  = dout_q;
`ifdef DIV_DBZ_FLAG_EN
        dbz_d   = dbz_q;
`endif

        // Shadow writes are accepted in every state; a running division works
        // from its own latched copies.
        if (wr_en) begin
            unique case (reg_sel)
                RegA:    a_d = d_in;
                RegB:    b_d = d_in;
                default: ;
            endcase
        end

        // Reads capture the pre-edge register contents.
        if (rd_en) begin
            dout_d = rd_data;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    wa_d    = a_q;
                    wb_d    = b_q;
                    rem_d   = '0;
                    cnt_d   = CntW'(WIDTH);
                    state_d = StRun;
`ifdef DIV_DBZ_FLAG_EN
                    dbz_d   = 1'b0;
`endif
                end
            end

            StRun: begin
                if (wb_q == '0) begin
                    // Zero divisor: finish on the first RUN edge.
                    q_d     = '1;
                    r_d     = wa_q;
                    cnt_d   = '0;
                    state_d = StDone;
`ifdef DIV_DBZ_FLAG_EN
                    dbz_d   = 1'b1;
`endif
                end else begin
                    wa_d  = quo_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q - CntW'(1);
                    // The final step's outcome goes straight to the result
                    // registers so done lands exactly WIDTH edges after start.
                    if (cnt_q == CntW'(1)) begin
                        q_d     = quo_next;
                        r_d     = rem_next;
                        state_d = StDone;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dout_q  <= '0;
`ifdef DIV_DBZ_FLAG_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dout_q  <= dout_d;
`ifdef DIV_DBZ_FLAG_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign d_out = dout_q;

endmodule

// File: tb/tb_peripheral_div.sv
// Testbench for peripheral_div: scoreboard of expected read data, checked by a
// monitor on the cycle after each read strobe, against a transaction-level
// model that computes results with / and % and tracks completion by edge index.

module tb_peripheral_div;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  d_in = '0;
    logic          cs = 1'b0;
    logic [4:0]    addr = '0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [31:0]   d_out;

    peripheral_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard.
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_tag = 1'b0;
    logic        chk_q = 1'b0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    always @(posedge clk) chk_q <= rd_tag;

    always @(negedge clk) begin
        if (chk_q) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got read data 0x%08h, expected none queued",
                         d_out);
            end else begin
                check(name_q.pop_front(), d_out, exp_q.pop_front());
            end
        end
    end

    // Reference model.
    logic [W-1:0] m_a, m_b, m_q, m_r, p_q, p_r;
    bit           m_done, m_dbz, p_dbz, pending;
    int unsigned  fin;
    logic [31:0]  m_dout;

    function automatic void model_reset();
        m_a = '0; m_b = '0; m_q = '0; m_r = '0; p_q = '0; p_r = '0;
        m_done = 0; m_dbz = 0; p_dbz = 0; pending = 0; fin = 0; m_dout = '0;
    endfunction

    // Bring the model up to the state seen just before edge e.
    function automatic void sync(int unsigned e);
        if (pending && e > fin) begin
            m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_done = 1; pending = 0;
        end
    endfunction

    function automatic logic [31:0] model_reg(logic [4:0] a);
        logic [31:0] s;
        s = '0;
        case (a[4:2])
            3'd3: begin
                s[0] = m_done;
                s[1] = pending;
`ifdef DIV_DBZ_FLAG_EN
                s[2] = m_dbz;
`endif
            end
            3'd4: s = {16'h0, m_q};
            3'd5: s = {16'h0, m_r};
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic void model_start(int unsigned e);
        pending = 1; m_done = 0; m_dbz = 0;
        if (m_b == 0) begin
            fin = e + 1; p_q = '1; p_r = m_a; p_dbz = 1;
        end else begin
            fin = e + W; p_q = m_a / m_b; p_r = m_a % m_b; p_dbz = 0;
        end
    endfunction

    // Bus tasks: each occupies one clock, driven on the falling edge.
    task automatic bus_idle();
        @(negedge clk);
        reset = 0; cs = 0; rd = 0; wr = 0; rd_tag = 0;
        addr = 5'($urandom); d_in = W'($urandom);
    endtask

    task automatic bus_read(input logic [4:0] a, input logic c, input string nm);
        @(negedge clk);
        reset = 0; cs = c; addr = a; rd = 1; wr = 0; d_in = W'($urandom); rd_tag = 1;
        sync(cyc);
        if (c) m_dout = model_reg(a);
        exp_q.push_back(m_dout);
        name_q.push_back(nm);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [W-1:0] data, input logic c);
        int unsigned e;
        @(negedge clk);
        reset = 0; cs = c; addr = a; rd = 0; wr = 1; d_in = data; rd_tag = 0;
        e = cyc;
        sync(e);
        if (c) begin
            case (a[4:2])
                3'd0: m_a = data;
                3'd1: m_b = data;
                3'd2: if (data[0] && !pending) model_start(e);
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; cs = 0; rd = 0; wr = 0; rd_tag = 0;
        @(negedge clk);
        check("reset_dout", d_out, 32'h0);
        model_reset();
        reset = 0;
    endtask

    // Poll status every cycle until the model reports completion.
    task automatic poll_done(input string nm);
        bit finished;
        finished = 0;
        for (int i = 0; i < 64; i++) begin
            bus_read(5'h0C, 1'b1, nm);
            if (m_done) begin
                finished = 1;
                break;
            end
        end
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no completion within 64 cycles, expected done", nm);
        end
    endtask

    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
        bus_write(5'h00, a, 1'b1);
        bus_write(5'h04, b, 1'b1);
        bus_write(5'h08, 16'h0001, 1'b1);
    endtask

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
        start_div(a, b);
        poll_done({nm, "_status"});
        bus_read(5'h10, 1'b1, {nm, "_q"});
        bus_read(5'h14, 1'b1, {nm, "_r"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb;
        int unsigned  sel;

        model_reset();
        do_reset();
        bus_read(5'h0C, 1'b1, "reset_status");
        bus_read(5'h10, 1'b1, "reset_q");
        bus_read(5'h14, 1'b1, "reset_r");

        // Basic divisions and latency (status polled every cycle).
        do_div(16'd100, 16'd7, "div_100_7");
        do_div(16'hFFFF, 16'd1, "div_ffff_1");
        do_div(16'd5, 16'd9, "div_5_9");
        do_div(16'd1234, 16'd0, "div_by_zero");

        // Start and B write during RUN: in-flight result unaffected.
        start_div(16'd100, 16'd7);
        bus_idle();
        bus_read(5'h10, 1'b1, "old_q_during_run");
        bus_write(5'h04, 16'd3, 1'b1);
        bus_write(5'h08, 16'h0001, 1'b1);
        poll_done("restart_ignored_status");
        bus_read(5'h10, 1'b1, "restart_ignored_q");
        bus_read(5'h14, 1'b1, "restart_ignored_r");
        bus_write(5'h08, 16'h0001, 1'b1);
        poll_done("shadow_b_status");
        bus_read(5'h10, 1'b1, "shadow_b_q");
        bus_read(5'h14, 1'b1, "shadow_b_r");

        // Control write with bit0 clear is a no-op.
        bus_write(5'h08, 16'hFFFE, 1'b1);
        bus_read(5'h0C, 1'b1, "ctrl_noop_status");

        // Reset mid-division.
        start_div(16'd100, 16'd7);
        repeat (4) bus_idle();
        do_reset();
        bus_read(5'h0C, 1'b1, "midrun_reset_status");
        bus_read(5'h10, 1'b1, "midrun_reset_q");
        bus_read(5'h14, 1'b1, "midrun_reset_r");
        do_div(16'd100, 16'd7, "after_reset");

        // Chip-select gating and undefined offset.
        bus_read(5'h10, 1'b1, "q_before_cs0");
        bus_read(5'h0C, 1'b0, "cs0_read_holds");
        bus_write(5'h00, 16'd999, 1'b0);
        bus_write(5'h08, 16'h0001, 1'b0);
        bus_read(5'h0C, 1'b1, "cs0_write_ignored");
        bus_read(5'h1C, 1'b1, "undef_offset");

        // Randomized divisions.
        for (int i = 0; i < 30; i++) begin
            ra  = W'($urandom);
            sel = $urandom_range(0, 4);
            if (sel == 0) rb = '0;
            else if (sel == 1) rb = W'($urandom_range(1, 15));
            else rb = W'($urandom);
            if (i % 5 == 2) bus_write(5'h04, W'($urandom), 1'b0);
            start_div(ra, rb);
            if (i % 3 == 0) bus_read(5'h14, 1'b1, "rand_r_in_flight");
            if (i % 4 == 1) bus_write(5'h00, W'($urandom), 1'b1);
            poll_done("rand_status");
            bus_read(5'h10, 1'b1, "rand_q");
            bus_read(5'h14, 1'b1, "rand_r");
        end

        repeat (3) bus_idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_div.md
# peripheral_div

Memory-mapped unsigned integer divider peripheral on the SoC data bus, selected by chip-select line cs[2] (address window 0x0043_xxxx). The CPU writes dividend and divisor, triggers a start, polls a done flag, and reads back quotient and remainder. A sequential restoring algorithm retires one quotient bit per clock. The result word drives the `div_dout` input of the SoC read-data multiplexer.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width in bits; quotient and remainder are zero-extended to 32 bits on `d_out`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset (the SoC drives `!resetn`).
- `d_in`  in  WIDTH  write data (SoC connects `mem_wdata[15:0]`).
- `cs`  in  1  chip select; the block ignores `rd`/`wr` when low.
- `addr`  in  5  register offset (`mem_addr[4:0]`).
- `rd`  in  1  read strobe.
- `wr`  in  1  write strobe (OR of byte mask).
- `d_out`  out  32  registered read data.

## Operation
Register map (byte offsets; `addr[1:0]` ignored):
- 0x00 W: dividend A shadow register.
- 0x04 W: divisor B shadow register.
- 0x08 W: control; `d_in[0]`=1 issues start, 0 is a no-op.
- 0x0C R: status; bit0 = done, bit1 = busy, bit2 = div-by-zero flag (only with the macro, otherwise 0).
- 0x10 R: quotient Q.
- 0x14 R: remainder R.
- Other offsets: writes ignored, reads return 0.

State machine: IDLE, RUN, DONE.
- IDLE/DONE + start: latch A and B into working registers, clear done, clear div-by-zero flag, load bit counter = WIDTH, and go to RUN.
- Start with latched B == 0: skip RUN. Next edge: Q = all ones, R = A, done = 1, div-by-zero flag = 1, state DONE.
- RUN: each cycle, shift {partial remainder, dividend} left by 1. If partial remainder ≥ B, subtract B and shift in quotient bit 1; otherwise shift in 0. Decrement the counter.
- When the counter reaches 0: write Q and R to the result registers, set done = 1, and go to DONE. The partial remainder is WIDTH+1 bits wide internally so the subtraction never overflows.
- RUN + start: ignored; the operation in flight is unaffected.
- Writes to A/B during RUN: they update the shadow registers only and are used by the next start.
- Q/R registers keep the previous result until the new one completes. Reads during RUN return the old values.
- `reset` at any time, including mid-RUN: state IDLE; A, B, Q, R, working registers, counter, flags, and `d_out` all go to 0. No partial result is retained.

## Timing
- Reset value of every output: `d_out` = 0x0000_0000.
- Reads: on the edge where `cs & rd` is high, `d_out` loads the addressed register. The value is valid the following cycle. Otherwise `d_out` holds.
- Writes: take effect on the edge where `cs & wr` is high.
- Latency: start written at edge N. For a nonzero divisor, done = 1 and Q/R are valid after edge N+WIDTH (16 cycles at default). For a zero divisor, after edge N+1.
- Status: busy = 1 from edge N until the edge that sets done.
- Simultaneous `rd` and `wr` to the same cycle: both are performed. A read of the status register on the start edge returns the pre-start status.

## Configuration
- `DIV_DBZ_FLAG_EN` defined: the div-by-zero flag is implemented and reported at status bit2.
- Without it: no flag register; status bit2 reads 0. The divide-by-zero result behaviour (Q = all ones, R = A, one-cycle completion) is unchanged.

## Test plan
- Write A=100, B=7, start at edge N → status reads busy=1 until edge N+16. Then done=1; Q=0x0000000E, R=0x00000002.
- A=0xFFFF, B=1 → Q=0x0000FFFF, R=0 after 16 cycles. A=5, B=9 → Q=0, R=5.
- A=1234, B=0, start → done after 1 cycle; Q=0x0000FFFF, R=0x000004D2. Status=0x5 with `DIV_DBZ_FLAG_EN`, 0x1 without.
- Start 100/7, then write B=3 and re-issue start mid-RUN → result is still Q=14, R=2. A following start gives Q=33, R=1.
- Assert `reset` 5 cycles into a division → next cycle status=0, Q=0, R=0, `d_out`=0. A fresh 100/7 then completes normally.
- Read with `cs`=0 or an undefined offset (0x1C) → `d_out` unchanged for `cs`=0; 0 for 0x1C.
